// File: rtl/pwm_pkg.sv
// Shared types for the PWM write-port controller.
//   pwm_sel_t    : generator sel codes (NOP, CMP, TOP, CNT load)
//   ctrl_state_t : commit FSM states
package pwm_pkg;

  typedef enum logic [1:0] {
    PWM_NOP = 2'b00,
    PWM_CMP = 2'b01,
    PWM_TOP = 2'b10,
    PWM_CNT = 2'b11
  } pwm_sel_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WRAP = 2'd1,
    APPLY_TOP = 2'd2,
    APPLY_CMP = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/pwm_update_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   en      : when low no grant is issued
//   ptr     : highest-priority index this cycle
//   gnt     : one-hot grant (or zero)
//   gnt_idx : index of the granted requester (0 when no grant)
// The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic          found;
  logic [IW-1:0] idx;
  int            s;

  // Scan N positions starting at ptr, wrapping; first valid request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    s       = 0;
    for (int k = 0; k < N; k++) begin
      s = int'(ptr) + k;
      if (s >= N) s = s - N;
      idx = s[IW-1:0];
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/pwm_update_ctrl.sv
// Write-port controller in front of a PWM generator's d/sel port.
// Requesters post CMP/TOP/CNT writes via valid/ready; a round-robin arbiter
// accepts one per cycle. CMP/TOP land in shadow registers and are committed
// (TOP first, then CMP) right after a period boundary so a period never mixes
// settings. CNT loads are forwarded on the next cycle.
//
// Handshake: a request i is accepted in a cycle where req_valid[i] and
// req_ready[i] are both high. req_ready is combinational, one-hot or zero, and
// is held low during reset, during APPLY_TOP/APPLY_CMP and in the cycle a
// commit starts. A requester keeps valid/sel/data stable until accepted.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready per-requester handshake
//   req_sel, req_data   per-requester target code [2i+1:2i] and data [W*i+W-1:W*i]
//   pwm_cnt, pwm_top    generator counter/top, used for boundary detection
//   pwm_d, pwm_sel      registered write to generator (sel 00 = no write)
//   pending             any shadow dirty
//   busy                FSM not idle
module pwm_update_ctrl
  import pwm_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [2*N_REQ-1:0] req_sel,
  input  logic [W*N_REQ-1:0] req_data,
  input  logic [W-1:0]       pwm_cnt,
  input  logic [W-1:0]       pwm_top,
  output logic [W-1:0]       pwm_d,
  output logic [1:0]         pwm_sel,
  output logic               pending,
  output logic               busy
);

  localparam int IW = $clog2(N_REQ);

  ctrl_state_t   state, state_n;
  logic [IW-1:0] ptr;
  logic [W-1:0]  top_sh, cmp_sh;
  logic          top_dirty, cmp_dirty, top_dirty_n, cmp_dirty_n;

  logic          boundary;
  logic          arb_en;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0] gnt_idx;
  logic          accept;
  pwm_sel_t      acc_sel;
  logic [W-1:0]  acc_data;
  pwm_sel_t      out_sel_n;
  logic [W-1:0]  out_d_n;

  // Generator restarts on the edge after cnt reaches top.
  assign boundary = (pwm_cnt >= pwm_top);

  // A boundary only matters while waiting to commit; in that cycle the
  // commit owns the port and requests wait.
  assign arb_en = !rst &&
                  ((state == IDLE) || ((state == WAIT_WRAP) && !boundary));

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req     (req_valid),
    .en      (arb_en),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;

  // Select the granted requester's sel/data.
  always_comb begin
    acc_sel  = PWM_NOP;
    acc_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        acc_sel  = pwm_sel_t'(req_sel[2*i +: 2]);
        acc_data = req_data[W*i +: W];
      end
    end
  end

  // Dirty bits: cleared by the APPLY state that writes them, set by accepts.
  // Accepts never coincide with APPLY states.
  always_comb begin
    top_dirty_n = top_dirty;
    cmp_dirty_n = cmp_dirty;
    if (state == APPLY_TOP) top_dirty_n = 1'b0;
    if (state == APPLY_CMP) cmp_dirty_n = 1'b0;
    if (accept && (acc_sel == PWM_TOP)) top_dirty_n = 1'b1;
    if (accept && (acc_sel == PWM_CMP)) cmp_dirty_n = 1'b1;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (top_dirty_n || cmp_dirty_n) state_n = WAIT_WRAP;
      WAIT_WRAP: if (boundary) state_n = top_dirty ? APPLY_TOP : APPLY_CMP;
      APPLY_TOP: state_n = cmp_dirty ? APPLY_CMP : IDLE;
      APPLY_CMP: state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // The output register is loaded from the state being entered, so the
  // generator sees sel=10/01 exactly during APPLY_TOP/APPLY_CMP.
  always_comb begin
    out_sel_n = PWM_NOP;
    out_d_n   = pwm_d;
    if (state_n == APPLY_TOP) begin
      out_sel_n = PWM_TOP;
      out_d_n   = top_sh;
    end else if (state_n == APPLY_CMP) begin
      out_sel_n = PWM_CMP;
      out_d_n   = cmp_sh;
    end else if (accept && (acc_sel == PWM_CNT)) begin
      out_sel_n = PWM_CNT;
      out_d_n   = acc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      top_sh    <= '0;
      cmp_sh    <= '0;
      top_dirty <= 1'b0;
      cmp_dirty <= 1'b0;
      pwm_sel   <= PWM_NOP;
      pwm_d     <= '0;
    end else begin
      state     <= state_n;
      top_dirty <= top_dirty_n;
      cmp_dirty <= cmp_dirty_n;
      pwm_sel   <= out_sel_n;
      pwm_d     <= out_d_n;
      if (accept) begin
        ptr <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        if (acc_sel == PWM_TOP) top_sh <= acc_data;
        if (acc_sel == PWM_CMP) cmp_sh <= acc_data;
      end
    end
  end

  assign pending = top_dirty | cmp_dirty;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_pwm_update_ctrl.sv
// Directed bench for pwm_update_ctrl: inputs change 1 time unit after posedge,
// outputs are checked on the following negedge.
module tb_pwm_update_ctrl;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [2*N-1:0] req_sel;
  logic [W*N-1:0] req_data;
  logic [W-1:0]   pwm_cnt;
  logic [W-1:0]   pwm_top;
  logic [W-1:0]   pwm_d;
  logic [1:0]     pwm_sel;
  logic           pending;
  logic           busy;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] S_NOP = 2'b00;
  localparam logic [1:0] S_CMP = 2'b01;
  localparam logic [1:0] S_TOP = 2'b10;
  localparam logic [1:0] S_CNT = 2'b11;

  // clock
  always #5 clk = ~clk;

  pwm_update_ctrl #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sel   (req_sel),
    .req_data  (req_data),
    .pwm_cnt   (pwm_cnt),
    .pwm_top   (pwm_top),
    .pwm_d     (pwm_d),
    .pwm_sel   (pwm_sel),
    .pending   (pending),
    .busy      (busy)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] s,
                         input logic [W-1:0] d);
    req_valid[i]       = v;
    req_sel[2*i +: 2]  = s;
    req_data[W*i +: W] = d;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_sel   = '0;
    req_data  = '0;
    pwm_cnt   = '0;
    pwm_top   = 16'd99;

    // 1: reset with every requester valid (CNT loads 10,20,30,40)
    for (int i = 0; i < N; i++) set_req(i, 1'b1, S_CNT, W'(10 * (i + 1)));
    tick();
    tick();
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_sel", 32'(pwm_sel), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // 2: round-robin CNT loads
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rr_ready0", 32'(req_ready), 32'h1);
    for (int k = 1; k < N; k++) begin
      tick();
      @(negedge clk);
      check("rr_ready", 32'(req_ready), 32'(1 << k));
      check("rr_sel", 32'(pwm_sel), 32'(S_CNT));
      check("rr_d", 32'(pwm_d), 32'(10 * k));
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    check("rr_sel_last", 32'(pwm_sel), 32'(S_CNT));
    check("rr_d_last", 32'(pwm_d), 32'd40);
    check("rr_ready_idle", 32'(req_ready), 32'h0);
    tick();
    @(negedge clk);
    check("rr_sel_nop", 32'(pwm_sel), 32'(S_NOP));

    // 3: deferred commit TOP=49, CMP=12 (pointer now 0)
    tick();
    set_req(1, 1'b1, S_TOP, 16'd49);
    @(negedge clk);
    check("dc_ready_top", 32'(req_ready), 32'h2);
    tick();
    set_req(1, 1'b1, S_CMP, 16'd12);
    @(negedge clk);
    check("dc_ready_cmp", 32'(req_ready), 32'h2);
    check("dc_sel_hold0", 32'(pwm_sel), 32'(S_NOP));
    check("dc_pending", 32'(pending), 32'h1);
    check("dc_busy", 32'(busy), 32'h1);
    tick();
    set_req(1, 1'b0, S_NOP, 16'd0);
    pwm_cnt = 16'd50;
    @(negedge clk);
    check("dc_sel_hold1", 32'(pwm_sel), 32'(S_NOP));
    tick();
    pwm_cnt = 16'd98;
    @(negedge clk);
    check("dc_sel_hold2", 32'(pwm_sel), 32'(S_NOP));
    tick();
    pwm_cnt = 16'd99;
    @(negedge clk);
    check("dc_sel_bnd", 32'(pwm_sel), 32'(S_NOP));
    check("dc_busy_bnd", 32'(busy), 32'h1);
    tick();
    pwm_cnt = 16'd0;
    @(negedge clk);
    check("dc_top_sel", 32'(pwm_sel), 32'(S_TOP));
    check("dc_top_d", 32'(pwm_d), 32'd49);
    tick();
    @(negedge clk);
    check("dc_cmp_sel", 32'(pwm_sel), 32'(S_CMP));
    check("dc_cmp_d", 32'(pwm_d), 32'd12);
    tick();
    @(negedge clk);
    check("dc_end_sel", 32'(pwm_sel), 32'(S_NOP));
    check("dc_end_pending", 32'(pending), 32'h0);
    check("dc_end_busy", 32'(busy), 32'h0);

    // 4: last-wins CMP=5 then CMP=7 (pointer now 2)
    tick();
    set_req(2, 1'b1, S_CMP, 16'd5);
    @(negedge clk);
    check("lw_ready1", 32'(req_ready), 32'h4);
    tick();
    set_req(2, 1'b1, S_CMP, 16'd7);
    @(negedge clk);
    check("lw_ready2", 32'(req_ready), 32'h4);
    check("lw_sel_hold", 32'(pwm_sel), 32'(S_NOP));
    tick();
    set_req(2, 1'b0, S_NOP, 16'd0);
    pwm_cnt = 16'd99;
    @(negedge clk);
    check("lw_pending", 32'(pending), 32'h1);
    tick();
    pwm_cnt = 16'd0;
    @(negedge clk);
    check("lw_cmp_sel", 32'(pwm_sel), 32'(S_CMP));
    check("lw_cmp_d", 32'(pwm_d), 32'd7);
    tick();
    @(negedge clk);
    check("lw_end_sel", 32'(pwm_sel), 32'(S_NOP));
    check("lw_end_pending", 32'(pending), 32'h0);

    // 5: request collides with boundary (pointer now 3)
    tick();
    set_req(3, 1'b1, S_TOP, 16'd60);
    @(negedge clk);
    check("co_ready_top", 32'(req_ready), 32'h8);
    tick();
    set_req(3, 1'b0, S_NOP, 16'd0);
    set_req(0, 1'b1, S_CNT, 16'd77);
    pwm_cnt = 16'd99;
    @(negedge clk);
    check("co_ready_bnd", 32'(req_ready), 32'h0);
    check("co_busy_bnd", 32'(busy), 32'h1);
    tick();
    pwm_cnt = 16'd0;
    @(negedge clk);
    check("co_ready_apply", 32'(req_ready), 32'h0);
    check("co_top_sel", 32'(pwm_sel), 32'(S_TOP));
    check("co_top_d", 32'(pwm_d), 32'd60);
    tick();
    @(negedge clk);
    check("co_ready_idle", 32'(req_ready), 32'h1);
    check("co_sel_idle", 32'(pwm_sel), 32'(S_NOP));
    check("co_busy_idle", 32'(busy), 32'h0);
    tick();
    set_req(0, 1'b0, S_NOP, 16'd0);
    @(negedge clk);
    check("co_cnt_sel", 32'(pwm_sel), 32'(S_CNT));
    check("co_cnt_d", 32'(pwm_d), 32'd77);

    // 6: reset during APPLY_TOP with CMP dirty (pointer now 1)
    tick();
    set_req(1, 1'b1, S_TOP, 16'd33);
    @(negedge clk);
    check("ra_ready_top", 32'(req_ready), 32'h2);
    tick();
    set_req(1, 1'b1, S_CMP, 16'd44);
    @(negedge clk);
    check("ra_ready_cmp", 32'(req_ready), 32'h2);
    tick();
    set_req(1, 1'b0, S_NOP, 16'd0);
    pwm_cnt = 16'd99;
    @(negedge clk);
    check("ra_sel_bnd", 32'(pwm_sel), 32'(S_NOP));
    tick();
    pwm_cnt = 16'd0;
    rst = 1'b1;
    @(negedge clk);
    check("ra_top_sel", 32'(pwm_sel), 32'(S_TOP));
    check("ra_top_d", 32'(pwm_d), 32'd33);
    check("ra_pending_pre", 32'(pending), 32'h1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("ra_sel_after", 32'(pwm_sel), 32'(S_NOP));
    check("ra_busy_after", 32'(busy), 32'h0);
    check("ra_pending_after", 32'(pending), 32'h0);
    tick();
    @(negedge clk);
    check("ra_no_cmp", 32'(pwm_sel), 32'(S_NOP));
    check("ra_busy_still", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
